// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-sequencing controller.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_EXECUTE  = 3'd3,
        ST_IRQ_SAVE = 3'd4,
        ST_IRQ_VEC  = 3'd5,
        ST_HALT     = 3'd6,
        ST_FAULT    = 3'd7
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_IRQ_VECTOR = 32'h0000_0008;

    // Width of the FETCH wait counter; a disabled timeout still needs one bit.
    function automatic int unsigned wait_width(input int unsigned timeout);
        if (timeout == 32'd0) begin
            return 32'd1;
        end else begin
            return $clog2(timeout + 32'd1);
        end
    endfunction

endpackage

// File: rtl/fetch_seq_wait_counter.sv
// Clear/enable counter with a terminal-count flag, used to bound FETCH waits.
// o_tc is high on the enabled cycle that would make the TERMINAL-th count;
// TERMINAL of 0 disables the flag entirely.
module wait_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TERMINAL = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles; clear has priority so every FETCH visit starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_clear) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // Flag the cycle on which the terminal count is reached.
    always_comb begin
        o_tc = 1'b0;
        if ((TERMINAL != 32'd0) && i_enable && (r_count == WIDTH'(TERMINAL - 32'd1))) begin
            o_tc = 1'b1;
        end else begin
            o_tc = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Fetch/dispatch/execute sequencer driving the PC control pins, the IR load,
// interrupt entry (link save + vector load), halt and fetch-timeout fault.
// At most one PC bus driver is enabled in any state.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int unsigned      SIZE       = 32,
    parameter logic [SIZE-1:0]  IRQ_VECTOR = SIZE'(DEFAULT_IRQ_VECTOR),
    parameter int unsigned      TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic            pc_oe_a,
    output logic            pc_oe_b,
    output logic            pc_ld,
    output logic            pc_post_inc,
    output logic            ir_ld,
    output logic            exec_start,
    input  logic            exec_done,
    input  logic            exec_branch,
    output logic            lr_ld,
    output logic [SIZE-1:0] vec_bus,
    input  logic            irq,
    output logic            irq_ack,
    input  logic            halt,
    output logic            halted,
    output logic            fault,
    output logic [SIZE-1:0] retired
);

    localparam int unsigned WAIT_W = wait_width(TIMEOUT);

    fetch_state_e    r_state;
    fetch_state_e    w_next_state;
    logic            w_vec_oe;
    logic            w_retire;
    logic            w_wait_en;
    logic            w_wait_clr;
    logic            w_wait_tc;
    logic [SIZE-1:0] r_retired;

    // Counter runs only on non-ack FETCH cycles and is held at zero elsewhere.
    assign w_wait_en  = (r_state == ST_FETCH) && !mem_ack;
    assign w_wait_clr = (r_state != ST_FETCH);

    wait_counter #(
        .WIDTH    (WAIT_W),
        .TERMINAL (TIMEOUT)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wait_clr),
        .i_enable (w_wait_en),
        .o_tc     (w_wait_tc)
    );

    // State register; reset lands in IDLE so every decoded output drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode; ack/done-qualified outputs are Mealy.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        pc_oe_a      = 1'b0;
        pc_oe_b      = 1'b0;
        pc_ld        = 1'b0;
        pc_post_inc  = 1'b0;
        ir_ld        = 1'b0;
        exec_start   = 1'b0;
        lr_ld        = 1'b0;
        irq_ack      = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        w_vec_oe     = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                pc_oe_a = 1'b1;
                if (mem_ack) begin
                    ir_ld        = 1'b1;
                    pc_post_inc  = 1'b1;
                    w_next_state = ST_DISPATCH;
                end else if (w_wait_tc) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DISPATCH: begin
                exec_start   = 1'b1;
                w_next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (exec_done) begin
                    pc_ld    = exec_branch;
                    w_retire = 1'b1;
                    if (irq) begin
                        w_next_state = ST_IRQ_SAVE;
                    end else if (halt) begin
                        w_next_state = ST_HALT;
                    end else begin
                        w_next_state = ST_FETCH;
                    end
                end else begin
                    w_next_state = ST_EXECUTE;
                end
            end
            ST_IRQ_SAVE: begin
                pc_oe_b      = 1'b1;
                lr_ld        = 1'b1;
                w_next_state = ST_IRQ_VEC;
            end
            ST_IRQ_VEC: begin
                w_vec_oe     = 1'b1;
                pc_ld        = 1'b1;
                irq_ack      = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (irq) begin
                    w_next_state = ST_IRQ_SAVE;
                end else if (!halt) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_HALT;
                end
            end
            ST_FAULT: begin
                fault        = 1'b1;
                w_next_state = ST_FAULT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Retired-instruction count, wrapping naturally at the counter width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= {SIZE{1'b0}};
        end else if (w_retire) begin
            r_retired <= r_retired + SIZE'(1);
        end else begin
            r_retired <= r_retired;
        end
    end

    assign retired = r_retired;
    assign vec_bus = w_vec_oe ? IRQ_VECTOR : {SIZE{1'bz}};

endmodule

// File: tb/tb_fetch_seq.sv
// Directed-vector bench for fetch_seq (SIZE=8, TIMEOUT=4).
module tb_fetch_seq;

    localparam logic [10:0] K_REQ = 11'h400;
    localparam logic [10:0] K_OEA = 11'h200;
    localparam logic [10:0] K_OEB = 11'h100;
    localparam logic [10:0] K_LD  = 11'h080;
    localparam logic [10:0] K_INC = 11'h040;
    localparam logic [10:0] K_IRL = 11'h020;
    localparam logic [10:0] K_ST  = 11'h010;
    localparam logic [10:0] K_LR  = 11'h008;
    localparam logic [10:0] K_ACK = 11'h004;
    localparam logic [10:0] K_HLT = 11'h002;
    localparam logic [10:0] K_FLT = 11'h001;
    localparam logic [10:0] K_F   = 11'h600;
    localparam logic [10:0] K_FII = 11'h660;
    localparam logic [10:0] K_0   = 11'h000;

    localparam logic [4:0] I_A = 5'b10000;
    localparam logic [4:0] I_D = 5'b01000;
    localparam logic [4:0] I_B = 5'b00100;
    localparam logic [4:0] I_I = 5'b00010;
    localparam logic [4:0] I_H = 5'b00001;
    localparam logic [4:0] I_0 = 5'b00000;

    typedef struct packed {
        logic [4:0]  in;
        logic [10:0] ctrl;
        logic        rinc;
    } row_t;

    logic       clk;
    logic       rst;
    logic       mem_req, mem_ack, pc_oe_a, pc_oe_b, pc_ld, pc_post_inc, ir_ld;
    logic       exec_start, exec_done, exec_branch, lr_ld, irq, irq_ack;
    logic       halt, halted, fault;
    wire  [7:0] vec_bus;
    logic [7:0] retired;
    logic [10:0] w_ctrl;

    int total;
    int bad;
    logic [7:0] exp_ret;

    fetch_seq #(.SIZE(8), .IRQ_VECTOR(8'h08), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_oe_a(pc_oe_a), .pc_oe_b(pc_oe_b), .pc_ld(pc_ld),
        .pc_post_inc(pc_post_inc), .ir_ld(ir_ld), .exec_start(exec_start),
        .exec_done(exec_done), .exec_branch(exec_branch), .lr_ld(lr_ld),
        .vec_bus(vec_bus), .irq(irq), .irq_ack(irq_ack), .halt(halt),
        .halted(halted), .fault(fault), .retired(retired)
    );

    assign w_ctrl = {mem_req, pc_oe_a, pc_oe_b, pc_ld, pc_post_inc, ir_ld,
                     exec_start, lr_ld, irq_ack, halted, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Drive one vector, let combinational outputs settle, and sample.
    task automatic apply_row(input row_t r, output logic [10:0] c, output logic v, output logic [7:0] rt);
        {mem_ack, exec_done, exec_branch, irq, halt} = r.in;
        #1;
        c  = w_ctrl;
        v  = (vec_bus === 8'h08);
        rt = retired;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {mem_ack, exec_done, exec_branch, irq, halt} = I_0;
        #3;
        total++;
        if (w_ctrl !== K_0) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", w_ctrl, K_0); end
        total++;
        if (retired !== 8'h00 || vec_bus === 8'h08) begin
            bad++; $display("FAIL reset_state retired=%h vec=%h exp retired=00 vec undriven", retired, vec_bus);
        end
        exp_ret = 8'h00;
        release_rst();
    endtask

    task automatic test_basic();
        row_t rows [11] = '{
            {I_0, K_0, 1'b0}, {I_A, K_FII, 1'b0}, {I_0, K_ST, 1'b0}, {I_D, K_0, 1'b1},
            {I_0, K_F, 1'b0}, {I_0, K_F, 1'b0}, {I_A, K_FII, 1'b0}, {I_0, K_ST, 1'b0},
            {I_B, K_0, 1'b0}, {I_D | I_B, K_LD, 1'b1}, {I_0, K_F, 1'b0}};
        logic [10:0] c; logic v; logic [7:0] rt;
        for (int i = 0; i < 11; i++) begin
            apply_row(rows[i], c, v, rt);
            total++;
            if (c !== rows[i].ctrl) begin bad++; $display("FAIL basic_ctrl[%0d] got=%b exp=%b", i, c, rows[i].ctrl); end
            total++;
            if (v !== rows[i].ctrl[2]) begin bad++; $display("FAIL basic_vec[%0d] got=%b exp=%b", i, v, rows[i].ctrl[2]); end
            total++;
            if (rt !== exp_ret) begin bad++; $display("FAIL basic_retired[%0d] got=%h exp=%h", i, rt, exp_ret); end
            step();
            if (rows[i].rinc) exp_ret = exp_ret + 8'd1;
        end
    endtask

    task automatic test_irq();
        row_t rows [11] = '{
            {I_A, K_FII, 1'b0}, {I_0, K_ST, 1'b0}, {I_D | I_B | I_I, K_LD, 1'b1},
            {I_0, K_OEB | K_LR, 1'b0}, {I_0, K_LD | K_ACK, 1'b0},
            {I_A, K_FII, 1'b0}, {I_0, K_ST, 1'b0}, {I_D | I_I | I_H, K_0, 1'b1},
            {I_H, K_OEB | K_LR, 1'b0}, {I_H, K_LD | K_ACK, 1'b0}, {I_0, K_F, 1'b0}};
        logic [10:0] c; logic v; logic [7:0] rt;
        for (int i = 0; i < 11; i++) begin
            apply_row(rows[i], c, v, rt);
            total++;
            if (c !== rows[i].ctrl) begin bad++; $display("FAIL irq_ctrl[%0d] got=%b exp=%b", i, c, rows[i].ctrl); end
            total++;
            if (v !== rows[i].ctrl[2]) begin bad++; $display("FAIL irq_vec[%0d] got=%b exp=%b", i, v, rows[i].ctrl[2]); end
            total++;
            if (rt !== exp_ret) begin bad++; $display("FAIL irq_retired[%0d] got=%h exp=%h", i, rt, exp_ret); end
            step();
            if (rows[i].rinc) exp_ret = exp_ret + 8'd1;
        end
    endtask

    task automatic test_irq_lost();
        row_t rows [5] = '{
            {I_A, K_FII, 1'b0}, {I_I, K_ST, 1'b0}, {I_I, K_0, 1'b0},
            {I_D, K_0, 1'b1}, {I_0, K_F, 1'b0}};
        logic [10:0] c; logic v; logic [7:0] rt;
        for (int i = 0; i < 5; i++) begin
            apply_row(rows[i], c, v, rt);
            total++;
            if (c !== rows[i].ctrl) begin bad++; $display("FAIL lost_ctrl[%0d] got=%b exp=%b", i, c, rows[i].ctrl); end
            total++;
            if (rt !== exp_ret) begin bad++; $display("FAIL lost_retired[%0d] got=%h exp=%h", i, rt, exp_ret); end
            step();
            if (rows[i].rinc) exp_ret = exp_ret + 8'd1;
        end
    endtask

    task automatic test_halt();
        row_t rows [13] = '{
            {I_A, K_FII, 1'b0}, {I_0, K_ST, 1'b0}, {I_D | I_H, K_0, 1'b1},
            {I_H, K_HLT, 1'b0}, {I_H, K_HLT, 1'b0}, {I_H | I_I, K_HLT, 1'b0},
            {I_0, K_OEB | K_LR, 1'b0}, {I_0, K_LD | K_ACK, 1'b0},
            {I_A, K_FII, 1'b0}, {I_0, K_ST, 1'b0}, {I_D | I_H, K_0, 1'b1},
            {I_0, K_HLT, 1'b0}, {I_0, K_F, 1'b0}};
        logic [10:0] c; logic v; logic [7:0] rt;
        for (int i = 0; i < 13; i++) begin
            apply_row(rows[i], c, v, rt);
            total++;
            if (c !== rows[i].ctrl) begin bad++; $display("FAIL halt_ctrl[%0d] got=%b exp=%b", i, c, rows[i].ctrl); end
            total++;
            if (v !== rows[i].ctrl[2]) begin bad++; $display("FAIL halt_vec[%0d] got=%b exp=%b", i, v, rows[i].ctrl[2]); end
            total++;
            if (rt !== exp_ret) begin bad++; $display("FAIL halt_retired[%0d] got=%h exp=%h", i, rt, exp_ret); end
            step();
            if (rows[i].rinc) exp_ret = exp_ret + 8'd1;
        end
    endtask

    task automatic test_timeout();
        row_t rows [18] = '{
            {I_0, K_F, 1'b0}, {I_0, K_F, 1'b0}, {I_A, K_FII, 1'b0}, {I_0, K_ST, 1'b0},
            {I_D, K_0, 1'b1}, {I_0, K_F, 1'b0}, {I_0, K_F, 1'b0}, {I_0, K_F, 1'b0},
            {I_A, K_FII, 1'b0}, {I_0, K_ST, 1'b0}, {I_D, K_0, 1'b1},
            {I_0, K_F, 1'b0}, {I_0, K_F, 1'b0}, {I_0, K_F, 1'b0}, {I_0, K_F, 1'b0},
            {I_A, K_FLT, 1'b0}, {I_A | I_D, K_FLT, 1'b0}, {I_I | I_H, K_FLT, 1'b0}};
        logic [10:0] c; logic v; logic [7:0] rt;
        for (int i = 0; i < 18; i++) begin
            apply_row(rows[i], c, v, rt);
            total++;
            if (c !== rows[i].ctrl) begin bad++; $display("FAIL timeout_ctrl[%0d] got=%b exp=%b", i, c, rows[i].ctrl); end
            total++;
            if (rt !== exp_ret) begin bad++; $display("FAIL timeout_retired[%0d] got=%h exp=%h", i, rt, exp_ret); end
            step();
            if (rows[i].rinc) exp_ret = exp_ret + 8'd1;
        end
        rst = 1'b1;
        #1;
        total++;
        if (w_ctrl !== K_0) begin bad++; $display("FAIL fault_rst_ctrl got=%b exp=%b", w_ctrl, K_0); end
        total++;
        if (retired !== 8'h00) begin bad++; $display("FAIL fault_rst_retired got=%h exp=00", retired); end
        exp_ret = 8'h00;
        {mem_ack, exec_done, exec_branch, irq, halt} = I_0;
        release_rst();
    endtask

    task automatic test_rst_fetch();
        #1;
        total++;
        if (w_ctrl !== K_0) begin bad++; $display("FAIL rstf_idle got=%b exp=%b", w_ctrl, K_0); end
        step();
        #1;
        total++;
        if (w_ctrl !== K_F) begin bad++; $display("FAIL rstf_fetch got=%b exp=%b", w_ctrl, K_F); end
        rst = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b0 || pc_oe_a !== 1'b0) begin
            bad++; $display("FAIL rstf_drop mem_req=%b pc_oe_a=%b exp=0", mem_req, pc_oe_a);
        end
        release_rst();
    endtask

    task automatic test_wrap();
        step();
        for (int n = 0; n < 255; n++) begin
            mem_ack = 1'b1; step();
            mem_ack = 1'b0; step();
            exec_done = 1'b1; step();
            exec_done = 1'b0;
        end
        #1;
        total++;
        if (retired !== 8'hFF) begin bad++; $display("FAIL wrap_255 got=%h exp=ff", retired); end
        mem_ack = 1'b1; step();
        mem_ack = 1'b0; step();
        exec_done = 1'b1; step();
        exec_done = 1'b0;
        #1;
        total++;
        if (retired !== 8'h00) begin bad++; $display("FAIL wrap_0 got=%h exp=00", retired); end
        total++;
        if (w_ctrl !== K_F) begin bad++; $display("FAIL wrap_state got=%b exp=%b", w_ctrl, K_F); end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            mem_ack     = ($urandom_range(3, 0) != 0);
            exec_done   = ($urandom_range(1, 0) != 0);
            exec_branch = ($urandom_range(1, 0) != 0);
            irq         = ($urandom_range(3, 0) == 0);
            halt        = ($urandom_range(3, 0) == 0);
            #1;
            total++;
            if (pc_oe_b === 1'b1 && vec_bus === 8'h08) begin
                bad++; $display("FAIL rand_excl[%0d] pc_oe_b=%b vec=%h exp not both driven", n, pc_oe_b, vec_bus);
            end
            total++;
            if (pc_oe_a !== mem_req) begin
                bad++; $display("FAIL rand_oea[%0d] pc_oe_a=%b exp=%b", n, pc_oe_a, mem_req);
            end
            step();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_irq();
        test_irq_lost();
        test_halt();
        test_timeout();
        test_rst_fetch();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
